// File: rtl/mac_tx_pkg.sv
// Shared types and constants for the MAC transmit framer.
package mac_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DATA,
    PAD,
    FCS,
    DROP,
    IFG
  } state_t;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_POLY      = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

endpackage

// File: rtl/mac_lfsr.sv
// Galois LFSR advancing DATA_WIDTH bits per valid beat; REVERSE=1 shifts LSB-first
// (reflected polynomial). init_i reloads LFSR_INIT synchronously.
module mac_lfsr #(
  parameter int unsigned              LFSR_WIDTH = 32,
  parameter logic [LFSR_WIDTH-1:0]    LFSR_POLY  = 32'h04C11DB7,
  parameter logic [LFSR_WIDTH-1:0]    LFSR_INIT  = '1,
  parameter bit                       REVERSE    = 1'b1,
  parameter int unsigned              DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  init_i,
  input  logic                  data_valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [LFSR_WIDTH-1:0] state_o
);

  function automatic logic [LFSR_WIDTH-1:0] bit_rev(input logic [LFSR_WIDTH-1:0] v);
    logic [LFSR_WIDTH-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < LFSR_WIDTH; i++) r[i] = v[LFSR_WIDTH-1-i];
    return r;
  endfunction

  localparam logic [LFSR_WIDTH-1:0] POLY_REV = bit_rev(LFSR_POLY);

  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
  logic                  fb;

  always_comb begin
    lfsr_d = lfsr_q;
    fb     = 1'b0;
    if (init_i) begin
      lfsr_d = LFSR_INIT;
    end else if (data_valid_i) begin
      for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
        if (REVERSE) begin
          fb     = lfsr_d[0] ^ data_i[i];
          lfsr_d = lfsr_d >> 1;
          if (fb) lfsr_d = lfsr_d ^ POLY_REV;
        end else begin
          fb     = lfsr_d[LFSR_WIDTH-1] ^ data_i[DATA_WIDTH-1-i];
          lfsr_d = lfsr_d << 1;
          if (fb) lfsr_d = lfsr_d ^ LFSR_POLY;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= LFSR_INIT;
    else         lfsr_q <= lfsr_d;
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/mac_tx_crc_insert.sv
// Transmit MAC framer: preamble+SFD, payload, optional zero pad, CRC-32 FCS, IFG.
// Define MAC_TX_PAD_EN to pad short frames up to MIN_FRAME_LEN before the FCS.
module mac_tx_crc_insert
  import mac_tx_pkg::*;
#(
  parameter int unsigned PREAMBLE_LEN  = 7,
  parameter int unsigned MIN_FRAME_LEN = 60,
  parameter int unsigned IFG_LEN       = 12
) (
  input  logic       phy_tx_clk,
  input  logic       phy_tx_rst_n,
  input  logic [7:0] mac_tdata_in,
  input  logic       mac_tvalid_in,
  output logic       mac_tready_out,
  input  logic       mac_tlast_in,
  input  logic       mac_tuser_in,
  output logic [7:0] phy_txd_out,
  output logic       phy_tvalid_out,
  output logic       phy_terr_out
);

`ifdef MAC_TX_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN);
  // The IDLE cycle taken before PREAMBLE completes the gap, so IFG itself runs one short.
  localparam logic [7:0]  IFG_LAST = 8'(IFG_LEN - 2);
  localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME_LEN);

  state_t      state_q;
  logic [7:0]  phase_q;
  logic [10:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]  txd_q;
  logic        tvalid_q, terr_q;

  logic        crc_init, crc_valid;
  logic [7:0]  crc_data;
  logic [31:0] crc_state, fcs;
  logic        short_frame;

  assign byte_cnt_d  = (byte_cnt_q == '1) ? byte_cnt_q : byte_cnt_q + 11'd1;
  assign short_frame = byte_cnt_d < MIN_LEN;

  assign crc_init  = (state_q == IDLE) && mac_tvalid_in;
  assign crc_valid = ((state_q == DATA) && mac_tvalid_in) || (state_q == PAD);
  assign crc_data  = (state_q == PAD) ? '0 : mac_tdata_in;
  assign fcs       = ~crc_state;

  mac_lfsr #(
    .LFSR_WIDTH (32),
    .LFSR_POLY  (CRC_POLY),
    .LFSR_INIT  (CRC_INIT),
    .REVERSE    (1'b1),
    .DATA_WIDTH (8)
  ) u_crc (
    .clk_i        (phy_tx_clk),
    .rst_ni       (phy_tx_rst_n),
    .init_i       (crc_init),
    .data_valid_i (crc_valid),
    .data_i       (crc_data),
    .state_o      (crc_state)
  );

  always_ff @(posedge phy_tx_clk or negedge phy_tx_rst_n) begin
    if (!phy_tx_rst_n) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      byte_cnt_q <= '0;
      txd_q      <= '0;
      tvalid_q   <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      txd_q    <= '0;
      tvalid_q <= 1'b0;
      terr_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          byte_cnt_q <= '0;
          phase_q    <= '0;
          if (mac_tvalid_in) state_q <= PREAMBLE;
        end
        PREAMBLE: begin
          tvalid_q <= 1'b1;
          if (phase_q == PRE_LAST) begin
            txd_q   <= SFD_BYTE;
            phase_q <= '0;
            state_q <= DATA;
          end else begin
            txd_q   <= PREAMBLE_BYTE;
            phase_q <= phase_q + 8'd1;
          end
        end
        DATA: begin
          tvalid_q <= 1'b1;
          if (!mac_tvalid_in) begin
            terr_q  <= 1'b1;
            state_q <= DROP;
          end else begin
            txd_q      <= mac_tdata_in;
            terr_q     <= mac_tuser_in;
            byte_cnt_q <= byte_cnt_d;
            if (mac_tuser_in) begin
              state_q <= mac_tlast_in ? IFG : DROP;
            end else if (mac_tlast_in) begin
              state_q <= (PAD_EN && short_frame) ? PAD : FCS;
            end
          end
        end
`ifdef MAC_TX_PAD_EN
        PAD: begin
          tvalid_q   <= 1'b1;
          byte_cnt_q <= byte_cnt_d;
          if (!short_frame) state_q <= FCS;
        end
`endif
        FCS: begin
          tvalid_q <= 1'b1;
          txd_q    <= fcs[{phase_q[1:0], 3'b000} +: 8];
          if (phase_q == 8'd3) begin
            phase_q <= '0;
            state_q <= IFG;
          end else begin
            phase_q <= phase_q + 8'd1;
          end
        end
        DROP: begin
          if (mac_tvalid_in && mac_tlast_in) begin
            phase_q <= '0;
            state_q <= IFG;
          end
        end
        IFG: begin
          if (phase_q == IFG_LAST) begin
            phase_q <= '0;
            state_q <= IDLE;
          end else begin
            phase_q <= phase_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mac_tready_out = (state_q == DATA) || (state_q == DROP);
  assign phy_txd_out    = txd_q;
  assign phy_tvalid_out = tvalid_q;
  assign phy_terr_out   = terr_q;

endmodule

// File: tb/tb_mac_tx_crc_insert.sv
// Directed bench for mac_tx_crc_insert; expectations follow MAC_TX_PAD_EN when defined.
module tb_mac_tx_crc_insert;

`ifdef MAC_TX_PAD_EN
  localparam bit PAD_ON = 1'b1;
`else
  localparam bit PAD_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] mac_tdata_in = '0;
  logic       mac_tvalid_in = 1'b0;
  logic       mac_tready_out;
  logic       mac_tlast_in = 1'b0;
  logic       mac_tuser_in = 1'b0;
  logic [7:0] phy_txd_out;
  logic       phy_tvalid_out;
  logic       phy_terr_out;

  always #5 clk = ~clk;

  mac_tx_crc_insert #(
    .PREAMBLE_LEN  (7),
    .MIN_FRAME_LEN (60),
    .IFG_LEN       (12)
  ) dut (
    .phy_tx_clk     (clk),
    .phy_tx_rst_n   (rst_n),
    .mac_tdata_in   (mac_tdata_in),
    .mac_tvalid_in  (mac_tvalid_in),
    .mac_tready_out (mac_tready_out),
    .mac_tlast_in   (mac_tlast_in),
    .mac_tuser_in   (mac_tuser_in),
    .phy_txd_out    (phy_txd_out),
    .phy_tvalid_out (phy_tvalid_out),
    .phy_terr_out   (phy_terr_out)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic       v;
    logic       e;
    logic       rdy;
    logic       al;
    logic [7:0] d;
  } smp_t;

  smp_t       cap[$];
  bit         cap_en = 1'b0;
  logic [7:0] pl[$];
  logic [7:0] expq[$];
  logic [31:0] exp_fcs;
  int         rs[$];
  int         rl[$];

  always @(negedge clk)
    if (cap_en)
      cap.push_back({phy_tvalid_out, phy_terr_out, mac_tready_out,
                     mac_tvalid_in & mac_tready_out & mac_tlast_in, phy_txd_out});

  function automatic logic [31:0] crc32_ref(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[k]) begin
      c = c ^ {24'd0, q[k]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic void build_exp();
    logic [7:0] body[$];
    body = pl;
    if (PAD_ON) while (body.size() < 60) body.push_back(8'h00);
    exp_fcs = crc32_ref(body);
    expq.delete();
    for (int k = 0; k < 7; k++) expq.push_back(8'h55);
    expq.push_back(8'hD5);
    foreach (body[k]) expq.push_back(body[k]);
    for (int k = 0; k < 4; k++) expq.push_back(exp_fcs[8*k +: 8]);
  endfunction

  function automatic void find_runs();
    rs.delete();
    rl.delete();
    foreach (cap[k]) begin
      if (cap[k].v && (k == 0 || !cap[k-1].v)) begin
        rs.push_back(k);
        rl.push_back(0);
      end
      if (cap[k].v) rl[rl.size()-1] = rl[rl.size()-1] + 1;
    end
  endfunction

  task automatic check_frame(input string tag, input int r);
    int mism = 0;
    int errs = 0;
    build_exp();
    if (r >= rs.size()) begin
      check_eq({tag, "_present"}, 0, 1);
    end else begin
      check_eq({tag, "_len"}, rl[r], expq.size());
      for (int k = 0; k < rl[r] && k < expq.size(); k++) begin
        if (cap[rs[r]+k].d !== expq[k]) mism++;
        if (cap[rs[r]+k].e) errs++;
      end
      check_eq({tag, "_bytes"}, mism, 0);
      check_eq({tag, "_terr"}, errs, 0);
    end
  endtask

  function automatic logic [31:0] run_fcs(input int r);
    int n;
    if (r >= rs.size() || rl[r] < 4) return 32'h0;
    n = rs[r] + rl[r];
    return {cap[n-1].d, cap[n-2].d, cap[n-3].d, cap[n-4].d};
  endfunction

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Sends `total` beats cycling over pl; tuser on beat user_idx; one underflow cycle after beat gap_after.
  task automatic drive(input int total, input int user_idx, input int gap_after);
    int i = 0;
    int cyc = 0;
    bit gapped = 1'b0;
    bit acc;
    int flen = pl.size();
    while (i < total && cyc < 4000) begin
      if (gap_after >= 0 && i == gap_after + 1 && !gapped) begin
        mac_tvalid_in = 1'b0;
        gapped = 1'b1;
      end else begin
        mac_tvalid_in = 1'b1;
        mac_tdata_in  = pl[i % flen];
        mac_tlast_in  = ((i % flen) == flen - 1);
        mac_tuser_in  = (i == user_idx);
      end
      @(negedge clk);
      acc = mac_tvalid_in && mac_tready_out;
      @(posedge clk);
      #1;
      if (acc) i++;
      cyc++;
    end
    mac_tvalid_in = 1'b0;
    mac_tlast_in  = 1'b0;
    mac_tuser_in  = 1'b0;
    check_eq("drive_done", i, total);
  endtask

  task automatic load_digits();
    pl.delete();
    for (int k = 0; k < 9; k++) pl.push_back(8'(8'h31 + k));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int j;
    int nrdy;
    int errs;
    int pad_n;
    pad_n = PAD_ON ? 51 : 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_txd", phy_txd_out, 8'h00);
    check_eq("rst_tvalid", phy_tvalid_out, 1'b0);
    check_eq("rst_terr", phy_terr_out, 1'b0);
    check_eq("rst_tready", mac_tready_out, 1'b0);
    rst_n = 1'b1;
    wait_cycles(2);

    // "123456789": CRC-32 check value 0xCBF43926, sent 26 39 F4 CB
    load_digits();
    cap.delete();
    cap_en = 1'b1;
    drive(9, -1, -1);
    wait_cycles(80);
    cap_en = 1'b0;
    find_runs();
    check_eq("t1_runs", rs.size(), 1);
    check_frame("t1", 0);
    check_eq("t1_fcs", run_fcs(0), PAD_ON ? exp_fcs : 32'hCBF43926);
    check_eq("t1_len_abs", rs.size() > 0 ? rl[0] : 0, PAD_ON ? 72 : 21);

    // Two back-to-back 64-byte frames, tvalid held high throughout
    pl.delete();
    for (int k = 0; k < 64; k++) pl.push_back(8'(k));
    cap.delete();
    cap_en = 1'b1;
    drive(128, -1, -1);
    wait_cycles(40);
    cap_en = 1'b0;
    find_runs();
    check_eq("t3_runs", rs.size(), 2);
    check_frame("t3a", 0);
    check_frame("t3b", 1);
    check_eq("t3_fcs", run_fcs(1), crc32_ref(pl));
    check_eq("t3_gap", rs.size() == 2 ? rs[1] - (rs[0] + rl[0]) : -1, 12);
    nrdy = 0;
    foreach (cap[k]) if (cap[k].rdy) nrdy++;
    check_eq("t3_tready_cycles", nrdy, 128);

    // Underflow after byte 10 of a 100-byte frame, then a normal frame
    pl.delete();
    for (int k = 0; k < 100; k++) pl.push_back(8'(k));
    cap.delete();
    cap_en = 1'b1;
    drive(100, -1, 9);
    load_digits();
    drive(9, -1, -1);
    wait_cycles(80);
    cap_en = 1'b0;
    find_runs();
    check_eq("t4_runs", rs.size(), 2);
    if (rs.size() == 2) begin
      check_eq("t4_abort_len", rl[0], 19);
      check_eq("t4_abort_byte", cap[rs[0]+18].d, 8'h00);
      check_eq("t4_abort_terr", cap[rs[0]+18].e, 1'b1);
      check_eq("t4_byte9", cap[rs[0]+17].d, 8'h09);
      errs = 0;
      for (int k = 0; k < rl[0]; k++) if (cap[rs[0]+k].e) errs++;
      check_eq("t4_terr_count", errs, 1);
      // IFG starts on the edge accepting tlast, as after a last FCS byte: 12 idle samples
      // follow the sample after that edge before the next preamble byte.
      j = -1;
      for (int k = 0; k < rs[1]; k++) if (cap[k].al) j = k;
      check_eq("t4_gap", rs[1] - j, 14);
      check_frame("t4b", 1);
    end

    // Async reset during FCS byte 2, then a clean frame
    load_digits();
    build_exp();
    drive(9, -1, -1);
    wait_cycles(pad_n + 3);
    check_eq("t5_fcs2_before_rst", phy_txd_out, exp_fcs[23:16]);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t5_rst_txd", phy_txd_out, 8'h00);
    check_eq("t5_rst_tvalid", phy_tvalid_out, 1'b0);
    check_eq("t5_rst_terr", phy_terr_out, 1'b0);
    check_eq("t5_rst_tready", mac_tready_out, 1'b0);
    wait_cycles(2);
    rst_n = 1'b1;
    cap.delete();
    cap_en = 1'b1;
    wait_cycles(3);
    drive(9, -1, -1);
    wait_cycles(80);
    cap_en = 1'b0;
    find_runs();
    check_eq("t5_runs", rs.size(), 1);
    check_eq("t5_idle_after_rst", cap[0].v, 1'b0);
    check_frame("t5", 0);
    check_eq("t5_fcs", run_fcs(0), PAD_ON ? exp_fcs : 32'hCBF43926);

    // tuser on byte 5, tlast on byte 20
    pl.delete();
    for (int k = 0; k < 20; k++) pl.push_back(8'(8'hA0 + k));
    cap.delete();
    cap_en = 1'b1;
    drive(20, 4, -1);
    wait_cycles(40);
    cap_en = 1'b0;
    find_runs();
    check_eq("t6_runs", rs.size(), 1);
    if (rs.size() == 1) begin
      check_eq("t6_len", rl[0], 13);
      check_eq("t6_last_byte", cap[rs[0]+rl[0]-1].d, 8'hA4);
      check_eq("t6_last_terr", cap[rs[0]+rl[0]-1].e, 1'b1);
      errs = 0;
      for (int k = 0; k < rl[0]; k++) if (cap[rs[0]+k].e) errs++;
      check_eq("t6_terr_count", errs, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
